// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID->EX pipeline register with valid/ready handshake and flush.
// Optional skid entry enabled by defining ID_EX_SKID_EN (capacity 2, fully
// registered ie_ready); default build is a single-entry stage.
module id_ex_pipe #(
  parameter int unsigned REG_W  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OP_W   = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ie_valid,
  output logic              ie_ready,
  input  logic [OP_W-1:0]   ie_alu_op,
  input  logic [SEL_W-1:0]  ie_alu_sel,
  input  logic [REG_W-1:0]  ie_src1,
  input  logic [REG_W-1:0]  ie_src2,
  input  logic [ADDR_W-1:0] ie_des_addr,
  input  logic              ie_des_exist,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_alu_op,
  output logic [SEL_W-1:0]  ex_alu_sel,
  output logic [REG_W-1:0]  ex_src1,
  output logic [REG_W-1:0]  ex_src2,
  output logic [ADDR_W-1:0] ex_des_addr,
  output logic              ex_des_exist
);

  localparam int unsigned PAY_W = OP_W + SEL_W + 2 * REG_W + ADDR_W + 1;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_pay;
  logic [PAY_W-1:0] main_pay_nxt;
  logic             main_valid;
  logic             main_valid_nxt;
  logic             accept;
  logic             deliver;

  assign in_pay = {ie_alu_op, ie_alu_sel, ie_src1, ie_src2, ie_des_addr, ie_des_exist};
  assign {ex_alu_op, ex_alu_sel, ex_src1, ex_src2, ex_des_addr, ex_des_exist} = main_pay;
  assign ex_valid = main_valid;
  assign accept   = ie_valid & ie_ready;
  assign deliver  = main_valid & ex_ready;

`ifdef ID_EX_SKID_EN

  logic [PAY_W-1:0] skid_pay;
  logic [PAY_W-1:0] skid_pay_nxt;
  logic             skid_valid;
  logic             skid_valid_nxt;
  logic             ready_q;
  logic             ready_nxt;

  // ie_ready comes straight from a flop: no ex_ready -> ie_ready path
  assign ie_ready = ready_q;

  // Next-state for main and skid entries; flush clears both
  always_comb begin
    main_pay_nxt   = main_pay;
    main_valid_nxt = main_valid;
    skid_pay_nxt   = skid_pay;
    skid_valid_nxt = skid_valid;
    if (flush) begin
      main_pay_nxt   = '0;
      main_valid_nxt = 1'b0;
      skid_pay_nxt   = '0;
      skid_valid_nxt = 1'b0;
    end else if (!main_valid || deliver) begin
      if (skid_valid) begin
        // Skid entry advances into main on the delivering edge
        main_pay_nxt   = skid_pay;
        main_valid_nxt = 1'b1;
        skid_pay_nxt   = '0;
        skid_valid_nxt = 1'b0;
      end else if (accept) begin
        main_pay_nxt   = in_pay;
        main_valid_nxt = 1'b1;
      end else begin
        main_pay_nxt   = '0;
        main_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      // Main entry stalled: park the incoming instruction in the skid entry
      skid_pay_nxt   = in_pay;
      skid_valid_nxt = 1'b1;
    end
    ready_nxt = ~skid_valid_nxt;
  end

  // Entry storage with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_pay   <= '0;
      main_valid <= 1'b0;
      skid_pay   <= '0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      main_pay   <= main_pay_nxt;
      main_valid <= main_valid_nxt;
      skid_pay   <= skid_pay_nxt;
      skid_valid <= skid_valid_nxt;
      ready_q    <= ready_nxt;
    end
  end

`else

  // Single entry: room whenever the entry is empty or leaving this cycle
  assign ie_ready = ex_ready | ~main_valid;

  // Next-state for the single entry; flush clears it and drops the input
  always_comb begin
    main_pay_nxt   = main_pay;
    main_valid_nxt = main_valid;
    if (flush) begin
      main_pay_nxt   = '0;
      main_valid_nxt = 1'b0;
    end else if (!main_valid || deliver) begin
      if (accept) begin
        main_pay_nxt   = in_pay;
        main_valid_nxt = 1'b1;
      end else begin
        main_pay_nxt   = '0;
        main_valid_nxt = 1'b0;
      end
    end
  end

  // Entry storage with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_pay   <= '0;
      main_valid <= 1'b0;
    end else begin
      main_pay   <= main_pay_nxt;
      main_valid <= main_valid_nxt;
    end
  end

`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed checks of id_ex_pipe (default widths and a
// 64-bit/6-bit-address instance); stall expectations follow ID_EX_SKID_EN.
module tb_id_ex_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Default-width instance
  logic        flush, ie_valid, ie_ready, ex_valid, ex_ready;
  logic [7:0]  ie_alu_op, ex_alu_op;
  logic [2:0]  ie_alu_sel, ex_alu_sel;
  logic [31:0] ie_src1, ie_src2, ex_src1, ex_src2;
  logic [4:0]  ie_des_addr, ex_des_addr;
  logic        ie_des_exist, ex_des_exist;

  id_ex_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ie_valid(ie_valid), .ie_ready(ie_ready),
    .ie_alu_op(ie_alu_op), .ie_alu_sel(ie_alu_sel),
    .ie_src1(ie_src1), .ie_src2(ie_src2),
    .ie_des_addr(ie_des_addr), .ie_des_exist(ie_des_exist),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_op(ex_alu_op), .ex_alu_sel(ex_alu_sel),
    .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_des_addr(ex_des_addr), .ex_des_exist(ex_des_exist)
  );

  // Wide instance
  logic        w_flush, w_ie_valid, w_ie_ready, w_ex_valid, w_ex_ready;
  logic [7:0]  w_ie_alu_op, w_ex_alu_op;
  logic [2:0]  w_ie_alu_sel, w_ex_alu_sel;
  logic [63:0] w_ie_src1, w_ie_src2, w_ex_src1, w_ex_src2;
  logic [5:0]  w_ie_des_addr, w_ex_des_addr;
  logic        w_ie_des_exist, w_ex_des_exist;

  id_ex_pipe #(.REG_W(64), .ADDR_W(6)) dut_w (
    .clk(clk), .rst(rst), .flush(w_flush),
    .ie_valid(w_ie_valid), .ie_ready(w_ie_ready),
    .ie_alu_op(w_ie_alu_op), .ie_alu_sel(w_ie_alu_sel),
    .ie_src1(w_ie_src1), .ie_src2(w_ie_src2),
    .ie_des_addr(w_ie_des_addr), .ie_des_exist(w_ie_des_exist),
    .ex_valid(w_ex_valid), .ex_ready(w_ex_ready),
    .ex_alu_op(w_ex_alu_op), .ex_alu_sel(w_ex_alu_sel),
    .ex_src1(w_ex_src1), .ex_src2(w_ex_src2),
    .ex_des_addr(w_ex_des_addr), .ex_des_exist(w_ex_des_exist)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input logic [4:0] addr, input logic ex);
    ie_valid = v; ie_alu_op = op; ie_alu_sel = sel;
    ie_src1 = s1; ie_src2 = s2; ie_des_addr = addr; ie_des_exist = ex;
  endtask

  logic exp_rdy;

  initial begin
    flush = 1'b0; ex_ready = 1'b0;
    drive(1'b0, 8'h0, 3'h0, 32'h0, 32'h0, 5'h0, 1'b0);
    w_flush = 1'b0; w_ie_valid = 1'b0; w_ex_ready = 1'b0;
    w_ie_alu_op = 8'h0; w_ie_alu_sel = 3'h0; w_ie_src1 = 64'h0; w_ie_src2 = 64'h0;
    w_ie_des_addr = 6'h0; w_ie_des_exist = 1'b0;

    // Reset held then released
    tick();
    chk("rst_ex_valid", 64'(ex_valid), 64'h0);
    chk("rst_ex_src1", 64'(ex_src1), 64'h0);
    #2 rst = 1'b1;
    tick();
    chk("rel_ie_ready", 64'(ie_ready), 64'h1);
    chk("rel_ex_valid", 64'(ex_valid), 64'h0);

    // Pass-through at full throughput
    ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i + 1), 3'(i), 32'(16 + i), 32'(256 + i), 5'(i + 1), 1'b1);
      tick();
      chk("pt_valid", 64'(ex_valid), 64'h1);
      chk("pt_op", 64'(ex_alu_op), 64'(i + 1));
      chk("pt_sel", 64'(ex_alu_sel), 64'(i));
      chk("pt_src1", 64'(ex_src1), 64'(16 + i));
      chk("pt_src2", 64'(ex_src2), 64'(256 + i));
      chk("pt_addr", 64'(ex_des_addr), 64'(i + 1));
      chk("pt_ready", 64'(ie_ready), 64'h1);
    end
    drive(1'b0, 8'h0, 3'h0, 32'h0, 32'h0, 5'h0, 1'b0);
    tick();
    chk("pt_drain_valid", 64'(ex_valid), 64'h0);
    chk("pt_nop_op", 64'(ex_alu_op), 64'h0);
    chk("pt_nop_src1", 64'(ex_src1), 64'h0);
    chk("pt_nop_exist", 64'(ex_des_exist), 64'h0);

    // Stall: A then B with ex_ready low
    ex_ready = 1'b0;
    drive(1'b1, 8'h0A, 3'h1, 32'hAAAA, 32'h1, 5'h1, 1'b1);
    tick();
    chk("st_a_src1", 64'(ex_src1), 64'hAAAA);
`ifdef ID_EX_SKID_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    chk("st_a_ready", 64'(ie_ready), 64'(exp_rdy));
    drive(1'b1, 8'h0B, 3'h2, 32'hBBBB, 32'h2, 5'h2, 1'b1);
    tick();
    chk("st_b_ready", 64'(ie_ready), 64'h0);
    chk("st_hold_src1", 64'(ex_src1), 64'hAAAA);
    tick();
    chk("st_hold2_op", 64'(ex_alu_op), 64'h0A);
    chk("st_hold2_valid", 64'(ex_valid), 64'h1);
    ex_ready = 1'b1;
`ifdef ID_EX_SKID_EN
    ie_valid = 1'b0;
`endif
    tick();
    chk("st_deliv_b", 64'(ex_src1), 64'hBBBB);
    chk("st_deliv_b_op", 64'(ex_alu_op), 64'h0B);
    ie_valid = 1'b0;
    tick();
    chk("st_empty", 64'(ex_valid), 64'h0);

    // Simultaneous accept and deliver
    drive(1'b1, 8'h0D, 3'h3, 32'h1111, 32'h0, 5'h3, 1'b0);
    tick();
    chk("sim_d", 64'(ex_src1), 64'h1111);
    drive(1'b1, 8'h0C, 3'h4, 32'h2222, 32'h0, 5'h5, 1'b1);
    tick();
    chk("sim_c_src1", 64'(ex_src1), 64'h2222);
    chk("sim_c_addr", 64'(ex_des_addr), 64'h5);
    chk("sim_c_exist", 64'(ex_des_exist), 64'h1);
    chk("sim_c_valid", 64'(ex_valid), 64'h1);
    ie_valid = 1'b0;
    tick();
    chk("sim_drain", 64'(ex_valid), 64'h0);

    // Flush with entries held and an incoming instruction
    ex_ready = 1'b0;
    drive(1'b1, 8'h0E, 3'h1, 32'h0E, 32'h0, 5'h4, 1'b1);
    tick();
    drive(1'b1, 8'h0F, 3'h1, 32'h0F, 32'h0, 5'h6, 1'b1);
    tick();
    chk("fl_pre_valid", 64'(ex_valid), 64'h1);
    flush = 1'b1;
    drive(1'b1, 8'h55, 3'h7, 32'hDEAD, 32'h1, 5'h7, 1'b1);
    tick();
    flush = 1'b0;
    ie_valid = 1'b0;
    chk("fl_valid", 64'(ex_valid), 64'h0);
    chk("fl_src1", 64'(ex_src1), 64'h0);
    chk("fl_op", 64'(ex_alu_op), 64'h0);
    chk("fl_addr", 64'(ex_des_addr), 64'h0);
    chk("fl_ready", 64'(ie_ready), 64'h1);
    ex_ready = 1'b1;
    tick();
    chk("fl_no_dead", 64'(ex_valid), 64'h0);
    chk("fl_no_dead_src1", 64'(ex_src1), 64'h0);

    // Asynchronous reset mid-cycle while holding an entry
    ex_ready = 1'b0;
    drive(1'b1, 8'h07, 3'h1, 32'h77, 32'h0, 5'h1, 1'b1);
    tick();
    ie_valid = 1'b0;
    chk("ar_pre_valid", 64'(ex_valid), 64'h1);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", 64'(ex_valid), 64'h0);
    chk("ar_src1", 64'(ex_src1), 64'h0);
    #2 rst = 1'b1;
    tick();
    chk("ar_rel_ready", 64'(ie_ready), 64'h1);
    chk("ar_rel_valid", 64'(ex_valid), 64'h0);

    // Wide instance pass-through
    w_ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_ie_valid = 1'b1; w_ie_alu_op = 8'(i + 1); w_ie_src1 = 64'(16 + i);
      w_ie_src2 = 64'hFFFF_FFFF_0000_0001; w_ie_des_addr = 6'd63; w_ie_des_exist = 1'b1;
      tick();
      chk("w_valid", 64'(w_ex_valid), 64'h1);
      chk("w_op", 64'(w_ex_alu_op), 64'(i + 1));
      chk("w_src1", w_ex_src1, 64'(16 + i));
      chk("w_src2", w_ex_src2, 64'hFFFF_FFFF_0000_0001);
      chk("w_addr", 64'(w_ex_des_addr), 64'd63);
    end
    w_ie_valid = 1'b0;
    tick();
    chk("w_drain", 64'(w_ex_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter: REG_W, default 32, operand width of src1/src2.
REQ-002 Parameter: ADDR_W, default 5, destination register address width.
REQ-003 Parameter: OP_W, default 8, ALU opcode width.
REQ-004 Parameter: SEL_W, default 3, ALU result-select width.
REQ-005 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Port: rst  input  1  reset, asynchronous, active-low.
REQ-007 Port: flush  input  1  discard all held and incoming instructions.
REQ-008 Port: ie_valid  input  1  ID stage presents an instruction.
REQ-009 Port: ie_ready  output  1  stage can accept an instruction this cycle.
REQ-010 Ports: ie_alu_op (OP_W), ie_alu_sel (SEL_W), ie_src1 and ie_src2 (REG_W), ie_des_addr (ADDR_W), ie_des_exist (1); all inputs, forming the ID payload.
REQ-011 Port: ex_valid  output  1  EX payload is valid.
REQ-012 Port: ex_ready  input  1  EX stage consumes the payload this cycle.
REQ-013 Ports: ex_alu_op, ex_alu_sel, ex_src1, ex_src2, ex_des_addr, ex_des_exist; outputs with the same widths as the ID payload; all registered.

Function
REQ-014 Accept: the stage SHALL accept a transfer when ie_valid=1 and ie_ready=1 in the same cycle.
REQ-015 Deliver: the stage SHALL deliver a transfer when ex_valid=1 and ex_ready=1 in the same cycle.
REQ-016 Latency: an accepted payload into an empty stage SHALL appear on the ex_* outputs with ex_valid=1 on the next cycle.
REQ-017 Ordering: payloads SHALL be delivered in acceptance order; none shall be lost or duplicated.
REQ-018 Stall hold: while ex_valid=1 and ex_ready=0, all ex_* outputs SHALL hold stable.
REQ-019 Nop outputs: when the stage holds no valid entry, all ex_* payload outputs SHALL read zero (nop op, nop select, zero operands, address 0, des_exist=0).
REQ-020 Flush priority: flush=1 SHALL invalidate every held entry on the next edge and force the payload outputs to zero.
REQ-021 Flush drop: an input presented in a flush cycle SHALL be dropped.
REQ-022 Flush vs deliver: flush SHALL take priority over a simultaneous accept or deliver.
REQ-023 Ready after flush: ie_ready SHALL be 1 in the cycle following a flush.
REQ-024 Full-throughput: with ex_ready held at 1, the stage SHALL sustain one transfer per cycle.

Reset
REQ-025 Reset assertion: asserting rst low SHALL immediately, without waiting for clk, clear every valid flag and set all ex_* outputs to zero.
REQ-026 Mid-operation reset: reset during operation SHALL discard in-flight entries exactly as in REQ-025.
REQ-027 Reset release: after rst is released, ie_ready SHALL be 1 and ex_valid SHALL be 0 until the first accept.

Configuration
REQ-028 ID_EX_SKID_EN defined: the stage SHALL hold a second skid entry.
  - ie_ready SHALL be a pure register output equal to "skid entry empty".
  - An accept while the main entry is stalled SHALL go to the skid entry.
  - On delivery, the skid entry SHALL move to the main entry in the same edge.
  - Capacity is 2; there is no combinational path from ex_ready to ie_ready.
REQ-029 ID_EX_SKID_EN undefined: the stage SHALL hold a single entry.
  - ie_ready = ex_ready OR NOT ex_valid, combinationally.
  - Capacity is 1.
  - All other requirements are unchanged.

Verification
REQ-030 Reset: drive rst=0 mid-cycle while ex_valid=1 -> ex_valid=0 and ex_src1=0 before the next clk edge; after release ie_ready=1.
REQ-031 Pass-through: ex_ready=1; accept ops 0x01..0x04 with src1=0x10..0x13 on consecutive cycles -> the same sequence appears on ex_* one cycle later, ex_valid stays 1 throughout.
REQ-032 Stall, ID_EX_SKID_EN defined: ex_ready=0; accept A (src1=0xAAAA), then B (src1=0xBBBB) -> ie_ready=0 after B.
  - Raising ex_ready delivers A, then B.
  - With the macro undefined, B is held off and ie_ready=0 until A is delivered.
REQ-033 Flush: hold two entries, assert flush together with ie_valid=1 (src1=0xDEAD) -> next cycle ex_valid=0, all outputs zero, ie_ready=1; 0xDEAD is never delivered.
REQ-034 Simultaneous events: in one cycle, accept C (des_addr=5, des_exist=1) and deliver the main entry with no flush -> C is output next cycle; no entry is lost; occupancy is unchanged.
REQ-035 Width parameters: instantiate with REG_W=64 and ADDR_W=6; run REQ-031 with src2=0xFFFF_FFFF_0000_0001 and des_addr=63 -> bit-exact delivery.
